// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the pipeline control and the divider.
// The control stage drives the request side (master); the divider answers
// with busy/done and the two results (slave).
interface div_unit_if;
  logic        start;
  logic        sign;
  logic        flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, sign, flush, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, sign, flush, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for the MIPS-style div/divu instructions.
// Produces one quotient bit per cycle (MSB first) on operand magnitudes,
// then fixes signs in a dedicated FIX cycle before presenting the results.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// and goes straight to DONE one cycle after the request is accepted.
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  divBus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } divState_e;

  divState_e   stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [31:0] remQ, remD;
  logic [31:0] quoQ, quoD;
  logic [31:0] divisorQ, divisorD;
  logic [31:0] dividendQ, dividendD;
  logic        negQuoQ, negQuoD;
  logic        negRemQ, negRemD;
  logic        divZeroQ, divZeroD;
  logic [31:0] quotientQ, quotientD;
  logic [31:0] remainderQ, remainderD;

  logic [32:0] shifted;
  logic        fits;
  logic        takeStart;

  // Next-state logic: flush overrides everything, start is only taken in IDLE/DONE
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    remD       = remQ;
    quoD       = quoQ;
    divisorD   = divisorQ;
    dividendD  = dividendQ;
    negQuoD    = negQuoQ;
    negRemD    = negRemQ;
    divZeroD   = divZeroQ;
    quotientD  = quotientQ;
    remainderD = remainderQ;
    shifted    = {remQ, quoQ[31]};
    fits       = (shifted >= {1'b0, divisorQ});
    takeStart  = 1'b0;

    if (divBus.flush) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE, DONE: begin
          stateD    = IDLE;
          takeStart = divBus.start;
          if (divBus.start) begin
            cntD      = 5'd0;
            remD      = 32'd0;
            quoD      = (divBus.sign && divBus.dividend[31]) ? (~divBus.dividend + 32'd1)
                                                             : divBus.dividend;
            divisorD  = (divBus.sign && divBus.divisor[31]) ? (~divBus.divisor + 32'd1)
                                                            : divBus.divisor;
            dividendD = divBus.dividend;
            negQuoD   = divBus.sign && (divBus.dividend[31] ^ divBus.divisor[31]);
            negRemD   = divBus.sign && divBus.dividend[31];
            divZeroD  = (divBus.divisor == 32'd0);
`ifdef DIV_ZERO_FAST_EN
            if (divBus.divisor == 32'd0) begin
              stateD     = DONE;
              quotientD  = 32'hFFFF_FFFF;
              remainderD = divBus.dividend;
            end else begin
              stateD = CALC;
            end
`else
            stateD = CALC;
`endif
          end
        end
        CALC: begin
          remD = fits ? (shifted[31:0] - divisorQ) : shifted[31:0];
          quoD = {quoQ[30:0], fits};
          cntD = cntQ + 5'd1;
          if (cntQ == 5'd31) begin
            stateD = FIX;
          end
        end
        FIX: begin
          stateD     = DONE;
          quotientD  = divZeroQ ? 32'hFFFF_FFFF : (negQuoQ ? (~quoQ + 32'd1) : quoQ);
          remainderD = divZeroQ ? dividendQ     : (negRemQ ? (~remQ + 32'd1) : remQ);
        end
        default: stateD = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      cntQ       <= 5'd0;
      remQ       <= 32'd0;
      quoQ       <= 32'd0;
      divisorQ   <= 32'd0;
      dividendQ  <= 32'd0;
      negQuoQ    <= 1'b0;
      negRemQ    <= 1'b0;
      divZeroQ   <= 1'b0;
      quotientQ  <= 32'd0;
      remainderQ <= 32'd0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      remQ       <= remD;
      quoQ       <= quoD;
      divisorQ   <= divisorD;
      dividendQ  <= dividendD;
      negQuoQ    <= negQuoD;
      negRemQ    <= negRemD;
      divZeroQ   <= divZeroD;
      quotientQ  <= quotientD;
      remainderQ <= remainderD;
    end
  end

  assign divBus.busy      = (stateQ == CALC) || (stateQ == FIX);
  assign divBus.done      = (stateQ == DONE);
  assign divBus.quotient  = quotientQ;
  assign divBus.remainder = remainderQ;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: unsigned/signed divides, overflow wrap,
// divide-by-zero (both DIV_ZERO_FAST_EN builds), back-to-back starts,
// flush and reset aborts. All expected values are hand-computed constants.
module tb_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_unit_if divBus ();

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .divBus (divBus.slave)
  );

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 34;
  localparam int ZERO_BUSY = 33;
`endif

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let it be sampled at the next edge (the accept edge)
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b);
    divBus.start    = 1'b1;
    divBus.sign     = sgn;
    divBus.dividend = a;
    divBus.divisor  = b;
    stepCycle();
    divBus.start    = 1'b0;
  endtask

  // Count edges from the accept edge until done is seen, and busy cycles on the way
  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 1;
    busyCnt = 0;
    while (divBus.done !== 1'b1 && lat < 100) begin
      if (divBus.busy === 1'b1) busyCnt++;
      stepCycle();
      lat++;
    end
  endtask

  // One full divide: request, latency, busy length and results
  task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int expLat, input int expBusy,
                           input logic [31:0] expQ, input logic [31:0] expR);
    int lat;
    int busyCnt;
    applyStimulus(sgn, a, b);
    waitDone(lat, busyCnt);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busyCycles"}, busyCnt, expBusy);
    checkOutput({tag, "_quotient"}, divBus.quotient, expQ);
    checkOutput({tag, "_remainder"}, divBus.remainder, expR);
  endtask

  // After a completed divide with no new start: done drops, results hold
  task automatic checkIdleAfter(input string tag, input logic [31:0] expQ,
                                input logic [31:0] expR);
    stepCycle();
    checkOutput({tag, "_doneDrop"}, divBus.done, 1'b0);
    checkOutput({tag, "_busyIdle"}, divBus.busy, 1'b0);
    checkOutput({tag, "_quotientHold"}, divBus.quotient, expQ);
    checkOutput({tag, "_remainderHold"}, divBus.remainder, expR);
  endtask

  // Main directed sequence
  initial begin
    int lat;
    int busyCnt;
    int doneSeen;
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    divBus.start    = 1'b0;
    divBus.sign     = 1'b0;
    divBus.flush    = 1'b0;
    divBus.dividend = 32'd0;
    divBus.divisor  = 32'd0;
    stepCycle();
    stepCycle();
    rst = 1'b0;

    checkOutput("reset_busy", divBus.busy, 1'b0);
    checkOutput("reset_done", divBus.done, 1'b0);
    checkOutput("reset_quotient", divBus.quotient, 32'd0);
    checkOutput("reset_remainder", divBus.remainder, 32'd0);

    // Unsigned 100 / 7
    runDivide("u100by7", 1'b0, 32'd100, 32'd7, 34, 33, 32'd14, 32'd2);
    checkIdleAfter("u100by7", 32'd14, 32'd2);

    // Signed cases
    runDivide("sNeg100by7", 1'b1, 32'hFFFF_FF9C, 32'd7, 34, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    checkIdleAfter("sNeg100by7", 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    runDivide("s100byNeg7", 1'b1, 32'd100, 32'hFFFF_FFF9, 34, 33, 32'hFFFF_FFF2, 32'd2);
    checkIdleAfter("s100byNeg7", 32'hFFFF_FFF2, 32'd2);
    runDivide("sMinByNeg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 33, 32'h8000_0000, 32'd0);
    checkIdleAfter("sMinByNeg1", 32'h8000_0000, 32'd0);

    // Unsigned max / 1, then a new start while in DONE
    runDivide("uMaxBy1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 33, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(1'b0, 32'd9, 32'd3);
    checkOutput("b2b_busyAfterAccept", divBus.busy, 1'b1);
    checkOutput("b2b_quotientHeld", divBus.quotient, 32'hFFFF_FFFF);
    waitDone(lat, busyCnt);
    checkOutput("b2b_latency", lat, 34);
    checkOutput("b2b_quotient", divBus.quotient, 32'd3);
    checkOutput("b2b_remainder", divBus.remainder, 32'd0);
    checkIdleAfter("b2b", 32'd3, 32'd0);

    // Divide by zero, unsigned and signed
    runDivide("u5by0", 1'b0, 32'd5, 32'd0, ZERO_LAT, ZERO_BUSY, 32'hFFFF_FFFF, 32'd5);
    checkIdleAfter("u5by0", 32'hFFFF_FFFF, 32'd5);
    runDivide("sNeg5by0", 1'b1, 32'hFFFF_FFFB, 32'd0, ZERO_LAT, ZERO_BUSY,
              32'hFFFF_FFFF, 32'hFFFF_FFFB);
    checkIdleAfter("sNeg5by0", 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Flush during CALC at cycle N+10
    applyStimulus(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) stepCycle();
    checkOutput("flush_busyBefore", divBus.busy, 1'b1);
    divBus.flush = 1'b1;
    stepCycle();
    divBus.flush = 1'b0;
    checkOutput("flush_busyAfter", divBus.busy, 1'b0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (divBus.done === 1'b1 || divBus.busy === 1'b1) doneSeen++;
      stepCycle();
    end
    checkOutput("flush_noDoneNoBusy", doneSeen, 0);
    checkOutput("flush_quotientHeld", divBus.quotient, 32'hFFFF_FFFF);
    checkOutput("flush_remainderHeld", divBus.remainder, 32'hFFFF_FFFB);

    // Flush and start in the same cycle: start is dropped
    divBus.flush = 1'b1;
    applyStimulus(1'b0, 32'd50, 32'd5);
    divBus.flush = 1'b0;
    checkOutput("flushStart_busy", divBus.busy, 1'b0);
    checkOutput("flushStart_done", divBus.done, 1'b0);
    stepCycle();
    checkOutput("flushStart_busyLater", divBus.busy, 1'b0);

    // Reset at cycle N+20 aborts the divide and clears outputs
    runDivide("preRst", 1'b0, 32'd100, 32'd7, 34, 33, 32'd14, 32'd2);
    checkIdleAfter("preRst", 32'd14, 32'd2);
    applyStimulus(1'b0, 32'd77, 32'd4);
    for (int i = 0; i < 19; i++) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst_busy", divBus.busy, 1'b0);
    checkOutput("rst_done", divBus.done, 1'b0);
    checkOutput("rst_quotient", divBus.quotient, 32'd0);
    checkOutput("rst_remainder", divBus.remainder, 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (divBus.done === 1'b1) doneSeen++;
      stepCycle();
    end
    checkOutput("rst_noDone", doneSeen, 0);
    runDivide("postRst", 1'b0, 32'd20, 32'd6, 34, 33, 32'd3, 32'd2);
    checkIdleAfter("postRst", 32'd3, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
